// File: rtl/spi_slave_rx_tx_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  // Default RAM byte width; frames carry two command bits on top of it.
  localparam int DATA_W_DEF = 8;

  // Command field values carried in the top two bits of each frame.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  // True for the states in which MOSI bits are shifted into the frame.
  function automatic logic is_shift_state(input state_e s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_slave_rx_tx_serializer.sv
// MISO byte serializer: loads a RAM read byte and shifts it out MSB first,
// one bit per clock, then returns MISO to 0. An abort drops the byte at once.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              miso,
  output logic              busy,
  output logic              last
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bits_left;
  logic [DATA_W-1:0] sreg;

  // Final bit is on MISO; the next edge ends the byte.
  assign last = busy && (bits_left == '0);

  // Control: MISO register, busy flag and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      busy      <= 1'b0;
      bits_left <= '0;
    end else if (abort) begin
      miso      <= 1'b0;
      busy      <= 1'b0;
      bits_left <= '0;
    end else if (load) begin
      miso      <= din[DATA_W-1];
      busy      <= 1'b1;
      bits_left <= CNT_START;
    end else if (busy) begin
      if (bits_left != '0) begin
        miso      <= sreg[DATA_W-1];
        bits_left <= bits_left - 1'b1;
      end else begin
        miso <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

  // Data: pending bits, pre-shifted so the next bit to send sits at the MSB.
  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= {din[DATA_W-2:0], 1'b0};
    end else if (busy && (bits_left != '0)) begin
      sreg <= {sreg[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave front end for the single-port RAM: deserialises MOSI frames onto
// rx_data/rx_valid and serialises the RAM read byte back out on MISO.
// Optional macro SPI_FRAME_ERR_EN adds a frame_err pulse on aborted transfers.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
`ifdef SPI_FRAME_ERR_EN
  output logic              frame_err,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  state_e state, state_nxt;

  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_nxt;
  logic               rd_addr_seen;
  logic               shifting;
  logic               sample;
  logic               last_bit;
  logic               frame_done;
  logic               ser_load;
  logic               ser_busy;
  logic               ser_last;

  assign shifting   = is_shift_state(state);
  // SS_n high on an edge is an abort, so it blocks the sample on that edge.
  assign sample     = shifting && !SS_n && (bit_cnt != CNT_FULL);
  assign last_bit   = sample && (bit_cnt == CNT_LAST);
  assign frame_nxt  = {shreg[FRAME_W-2:0], MOSI};
  assign frame_done = (bit_cnt == CNT_FULL);
  // A read byte is only accepted once the read-data frame has been delivered.
  assign ser_load   = (state == READ_DATA) && frame_done && !SS_n &&
                      tx_valid && !ser_busy;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; SS_n high returns to IDLE ahead of everything else.
  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI) begin
            state_nxt = WRITE;
          end else if (rd_addr_seen) begin
            state_nxt = READ_DATA;
          end else begin
            state_nxt = READ_ADD;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Frame control: saturating bit counter, frame delivery and read tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (SS_n || !shifting) begin
        bit_cnt <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (last_bit) begin
        rx_data <= frame_nxt;
      end
      if (last_bit && (state == READ_ADD)) begin
        rd_addr_seen <= 1'b1;
      end else if (ser_last && !SS_n) begin
        rd_addr_seen <= 1'b0;
      end
    end
  end

  // Frame assembly shift register, MSB first.
  always_ff @(posedge clk) begin
    if (sample) begin
      shreg <= frame_nxt;
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (SS_n),
    .load  (ser_load),
    .din   (tx_data),
    .miso  (MISO),
    .busy  (ser_busy),
    .last  (ser_last)
  );

`ifdef SPI_FRAME_ERR_EN
  // Abort flag: SS_n rose mid-frame or while a MISO byte was still going out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= SS_n &&
                   ((shifting && (bit_cnt != '0) && !frame_done) ||
                    (ser_busy && !ser_last));
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed testbench for spi_slave_rx_tx.
module tb_spi_slave_rx_tx;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_slave_rx_tx #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef SPI_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle then CHK_CMD cycle with the command-select bit on MOSI.
  task automatic start_frame(input logic cmd);
    SS_n = 1'b0;
    MOSI = cmd;
    tick();
    tick();
  endtask

  task automatic send_frame(input string tag, input logic [9:0] f);
    int early = 0;
    for (int k = 9; k >= 0; k--) begin
      MOSI = f[k];
      tick();
      if (k != 0 && rx_valid) early++;
    end
    check({tag, "_early_valid"}, 16'(early), 16'd0);
    check({tag, "_valid"}, 16'(rx_valid), 16'd1);
    check({tag, "_data"}, 16'(rx_data), 16'(f));
    tick();
    check({tag, "_valid_1cyc"}, 16'(rx_valid), 16'd0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    tick();
  endtask

  // Pulse tx_valid, then gather the 8 MISO bits and the idle level after.
  task automatic read_byte(input string tag, input logic [7:0] b);
    logic [7:0] got;
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      got[i] = MISO;
      if (i != 0) tick();
    end
    check({tag, "_miso_byte"}, 16'(got), 16'(b));
    tick();
    check({tag, "_miso_after"}, 16'(MISO), 16'd0);
  endtask

  // tx_valid pulse that must be ignored: MISO stays low throughout.
  task automatic stray_tx(input string tag, input logic [7:0] b);
    int hi = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    if (MISO) hi++;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (MISO || rx_valid) hi++;
    end
    check({tag, "_miso_quiet"}, 16'(hi), 16'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b0;
    MOSI     = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tick();
    tick();
    check("rst_rx_valid", 16'(rx_valid), 16'd0);
    check("rst_miso", 16'(MISO), 16'd0);
    check("rst_rx_data", 16'(rx_data), 16'h000);
`ifdef SPI_FRAME_ERR_EN
    check("rst_frame_err", 16'(frame_err), 16'd0);
`endif
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Write address frame, then stray tx_valid and extra bits in WRITE.
    start_frame(1'b0);
    send_frame("wr_addr", 10'h0A5);
    MOSI = 1'b1;
    stray_tx("stray_wr", 8'hFF);
    check("wr_hold_data", 16'(rx_data), 16'h0A5);
    end_frame();

    // After a write, a read command must take the READ_ADD path.
    start_frame(1'b1);
    send_frame("rd_addr", 10'h203);
    stray_tx("stray_rdadd", 8'hC3);
    end_frame();

    // Read data: frame, then the RAM byte goes out on MISO.
    start_frame(1'b1);
    send_frame("rd_data", 10'h300);
    read_byte("rd_c3", 8'hC3);
    tick();
    check("rd_c3_quiet", 16'(MISO), 16'd0);
    end_frame();

    // rd_addr_seen was cleared by the byte, so this is READ_ADD again.
    start_frame(1'b1);
    send_frame("rd_addr2", 10'h3AA);
    stray_tx("stray_rdadd2", 8'hC3);
    end_frame();

    // Abort after 6 of 10 bits.
    start_frame(1'b0);
    for (int k = 9; k >= 4; k--) begin
      MOSI = k[0];
      tick();
    end
    SS_n = 1'b1;
    tick();
    check("abort6_valid", 16'(rx_valid), 16'd0);
    check("abort6_data", 16'(rx_data), 16'h3AA);
`ifdef SPI_FRAME_ERR_EN
    check("abort6_ferr", 16'(frame_err), 16'd1);
`endif
    tick();
    check("abort6_valid2", 16'(rx_valid), 16'd0);
`ifdef SPI_FRAME_ERR_EN
    check("abort6_ferr_1cyc", 16'(frame_err), 16'd0);
`endif

    // Clean frame after the abort starts from an empty counter.
    start_frame(1'b0);
    send_frame("wr_after_abort", 10'h155);
    end_frame();

    // SS_n rises on the same edge as the last bit: abort wins.
    start_frame(1'b0);
    for (int k = 9; k >= 1; k--) begin
      MOSI = 1'b1;
      tick();
    end
    MOSI = 1'b1;
    SS_n = 1'b1;
    tick();
    check("lastbit_abort_valid", 16'(rx_valid), 16'd0);
    check("lastbit_abort_data", 16'(rx_data), 16'h155);
`ifdef SPI_FRAME_ERR_EN
    check("lastbit_abort_ferr", 16'(frame_err), 16'd1);
`endif
    tick();
    check("lastbit_abort_valid2", 16'(rx_valid), 16'd0);

    // rd_addr_seen is still set (from 0x3AA): read data, abort mid-byte.
    start_frame(1'b1);
    send_frame("rd_data2", 10'h3FF);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("abort_byte_b7", 16'(MISO), 16'd0);
    tick();
    check("abort_byte_b6", 16'(MISO), 16'd1);
    tick();
    SS_n = 1'b1;
    tick();
    check("abort_byte_miso", 16'(MISO), 16'd0);
`ifdef SPI_FRAME_ERR_EN
    check("abort_byte_ferr", 16'(frame_err), 16'd1);
`endif
    tick();

    // Abort does not clear rd_addr_seen: next read frame is READ_DATA.
    start_frame(1'b1);
    send_frame("rd_data3", 10'h300);
    read_byte("rd_81", 8'h81);
    end_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
